// File: rtl/servo_pkg.sv
// Shared servo types and constants: duty-count pulse widths and the 12-bit
// position scale used by both the capture block and the PID controller.
package servo_pkg;

   typedef logic [17:0] duty_t;
   typedef logic [11:0] pos_t;

   localparam int unsigned MIN_DUTY    = 50000;
   localparam int unsigned CENTER_DUTY = 75000;
   localparam int unsigned MAX_DUTY    = 100000;
   localparam int unsigned GLITCH_CYC  = 1000;
   localparam int unsigned TIMEOUT_CYC = 1200000;
   localparam int unsigned SCALE_MUL   = 5368;
   localparam int unsigned SCALE_SHIFT = 16;

   localparam pos_t POS_MAX    = 12'd4095;
   localparam pos_t POS_CENTER = 12'd2047;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_RISE = 2'd1,
      S_HIGH      = 2'd2
   } state_t;

   function automatic duty_t duty_sat_inc(input duty_t value);
      duty_t v_max;
      v_max = '1;
      return (value == v_max) ? value : value + duty_t'(1);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous PWM input plus an edge register
// that yields single-cycle rise/fall strobes on the synchronized level.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_pwm,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_level_d;

   // NOTE: non-blocking assignments make the three flops shift as a pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level_d <= 1'b0;
      end else begin
         r_sync1   <= i_pwm;
         r_sync2   <= r_sync1;
         r_level_d <= r_sync2;
      end
   end

   assign o_level = r_sync2;
   assign o_rise  = r_sync2 & ~r_level_d;
   assign o_fall  = ~r_sync2 & r_level_d;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures the high time of each pulse, converts it to a
// 12-bit position, and flags glitches, out-of-range widths and signal loss.
module servo_pwm_capture #(
   parameter int unsigned MIN_DUTY    = servo_pkg::MIN_DUTY,
   parameter int unsigned MAX_DUTY    = servo_pkg::MAX_DUTY,
   parameter int unsigned CENTER_DUTY = servo_pkg::CENTER_DUTY,
   parameter int unsigned GLITCH_CYC  = servo_pkg::GLITCH_CYC,
   parameter int unsigned TIMEOUT_CYC = servo_pkg::TIMEOUT_CYC,
   parameter int unsigned SCALE_MUL   = servo_pkg::SCALE_MUL,
   parameter int unsigned SCALE_SHIFT = servo_pkg::SCALE_SHIFT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pwm_in,
   output servo_pkg::duty_t   width_out,
   output servo_pkg::pos_t    position_out,
   output logic               meas_valid,
   output logic               out_of_range,
   output logic               signal_lost
);

   import servo_pkg::duty_t;
   import servo_pkg::pos_t;
   import servo_pkg::state_t;
   import servo_pkg::S_IDLE;
   import servo_pkg::S_WAIT_RISE;
   import servo_pkg::S_HIGH;
   import servo_pkg::POS_MAX;
   import servo_pkg::POS_CENTER;
   import servo_pkg::duty_sat_inc;

   localparam duty_t       MIN_W        = duty_t'(MIN_DUTY);
   localparam duty_t       MAX_W        = duty_t'(MAX_DUTY);
   localparam duty_t       CENTER_W     = duty_t'(CENTER_DUTY);
   localparam duty_t       GLITCH_W     = duty_t'(GLITCH_CYC);
   localparam logic [20:0] PERIOD_MAX   = '1;
   localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYC - 1);
   localparam logic [31:0] SCALE_MUL_W  = 32'(SCALE_MUL);

   logic        w_level;
   logic        w_rise;
   logic        w_fall;
   logic        w_timeout;

   state_t      r_state;
   duty_t       r_width;
   logic [20:0] r_period;
   duty_t       r_cap_width;
   logic        r_cap_vld;

   duty_t       w_diff;
   logic [31:0] w_prod;
   logic [31:0] w_shift;
   pos_t        w_pos;
   logic        w_oor;

   sync_edge_detect u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_pwm   (pwm_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // A rise strobe on the timeout cycle starts a new pulse instead of flagging loss.
   assign w_timeout = (r_state != S_IDLE) && !w_rise && (r_period == TIMEOUT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period <= '0;
      end else if ((r_state == S_IDLE) || w_rise) begin
         r_period <= '0;
      end else if (r_period != PERIOD_MAX) begin
         r_period <= r_period + 21'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_width     <= '0;
         r_cap_width <= '0;
         r_cap_vld   <= 1'b0;
      end else begin
         r_cap_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall) r_state <= S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
               if (w_rise) begin
                  r_state <= S_HIGH;
                  r_width <= duty_t'(1);
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            S_HIGH: begin
               if (w_timeout) begin
                  r_state <= S_IDLE;
               end else if (w_fall) begin
                  r_state <= S_WAIT_RISE;
                  if (r_width >= GLITCH_W) begin
                     r_cap_width <= r_width;
                     r_cap_vld   <= 1'b1;
                  end
               end else if (w_level) begin
                  r_width <= duty_sat_inc(r_width);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output of this block is assigned first so no latch is inferred.
   always_comb begin
      w_diff  = r_cap_width - MIN_W;
      w_prod  = 32'(w_diff) * SCALE_MUL_W;
      w_shift = w_prod >> SCALE_SHIFT;
      w_pos   = POS_MAX;
      w_oor   = 1'b0;
      if (r_cap_width < MIN_W) begin
         w_pos = '0;
         w_oor = 1'b1;
      end else if (r_cap_width > MAX_W) begin
         w_pos = POS_MAX;
         w_oor = 1'b1;
      end else if (w_shift > 32'(POS_MAX)) begin
         w_pos = POS_MAX;
      end else begin
         w_pos = w_shift[11:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_out    <= CENTER_W;
         position_out <= POS_CENTER;
         meas_valid   <= 1'b0;
         out_of_range <= 1'b0;
         signal_lost  <= 1'b1;
      end else begin
         meas_valid <= r_cap_vld;
         if (r_cap_vld) begin
            width_out    <= r_cap_width;
            position_out <= w_pos;
            out_of_range <= w_oor;
         end
         if (w_timeout) begin
            signal_lost <= 1'b1;
         end else if (r_cap_vld) begin
            signal_lost <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture, run with scaled-down timing parameters
// (1/100 of the production pulse widths) so whole frames fit in a short run.
module tb_servo_pwm_capture;

   localparam int MIN_D    = 500;
   localparam int MAX_D    = 1000;
   localparam int CENTER_D = 750;
   localparam int GLITCH   = 10;
   localparam int TIMEOUT  = 3000;
   localparam int SMUL     = 536800;
   localparam int SSHIFT   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwm_in;
   logic [17:0] width_out;
   logic [11:0] position_out;
   logic        meas_valid;
   logic        out_of_range;
   logic        signal_lost;

   always #5 clk = ~clk;

   servo_pwm_capture #(
      .MIN_DUTY    (MIN_D),
      .MAX_DUTY    (MAX_D),
      .CENTER_DUTY (CENTER_D),
      .GLITCH_CYC  (GLITCH),
      .TIMEOUT_CYC (TIMEOUT),
      .SCALE_MUL   (SMUL),
      .SCALE_SHIFT (SSHIFT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pwm_in       (pwm_in),
      .width_out    (width_out),
      .position_out (position_out),
      .meas_valid   (meas_valid),
      .out_of_range (out_of_range),
      .signal_lost  (signal_lost)
   );

   typedef struct {
      int high;
      int low;
      bit strobe;
      int w;
      int p;
      bit oor;
      bit lost;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model state: last accepted result and whether a falling edge
   // has been seen since reset/loss (the receiver only measures after one).
   bit m_armed;
   int m_w;
   int m_p;
   bit m_oor;
   bit m_lost;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int model_pos(input int w);
      longint p;
      if (w < MIN_D) return 0;
      if (w > MAX_D) return 4095;
      p = (longint'(w - MIN_D) * longint'(SMUL)) / (longint'(1) << SSHIFT);
      return (p > 4095) ? 4095 : int'(p);
   endfunction

   task automatic model_reset();
      m_armed = 1'b0;
      m_w     = CENTER_D;
      m_p     = 2047;
      m_oor   = 1'b0;
      m_lost  = 1'b1;
   endtask

   task automatic model_apply(input int high, output vec_t v);
      v.high   = high;
      v.strobe = m_armed && (high >= GLITCH);
      if (v.strobe) begin
         m_w    = (high > 262143) ? 262143 : high;
         m_p    = model_pos(m_w);
         m_oor  = (m_w < MIN_D) || (m_w > MAX_D);
         m_lost = 1'b0;
      end
      m_armed = 1'b1;
      v.w    = m_w;
      v.p    = m_p;
      v.oor  = m_oor;
      v.lost = m_lost;
   endtask

   task automatic run_pulse(input string name, input vec_t v);
      int first;
      int n;
      @(negedge clk);
      pwm_in = 1'b1;
      repeat (v.high) @(negedge clk);
      pwm_in = 1'b0;
      first = 0;
      n = 0;
      for (int i = 1; i <= v.low; i++) begin
         @(posedge clk);
         #1;
         if (meas_valid) begin
            n++;
            if (first == 0) first = i;
         end
      end
      check({name, "_strobes"}, n, v.strobe ? 1 : 0);
      if (v.strobe) check({name, "_latency"}, first, 4);
      check({name, "_width"}, int'(width_out), v.w);
      check({name, "_pos"}, int'(position_out), v.p);
      check({name, "_oor"}, int'(out_of_range), int'(v.oor));
      check({name, "_lost"}, int'(signal_lost), int'(v.lost));
   endtask

   task automatic model_pulse(input string name, input int high, input int low);
      vec_t v;
      model_apply(high, v);
      v.low = low;
      run_pulse(name, v);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      vec_t dummy;
      int   n;
      int   first_lost;
      int   hi;
      int   lo;

      rst    = 1'b1;
      pwm_in = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_width", int'(width_out), 750);
      check("reset_pos", int'(position_out), 2047);
      check("reset_valid", int'(meas_valid), 0);
      check("reset_oor", int'(out_of_range), 0);
      check("reset_lost", int'(signal_lost), 1);
      @(negedge clk);
      rst = 1'b0;

      // high, low, strobe, width, pos, oor, lost
      vecs.push_back('{750,  1250, 1'b0, 750,  2047, 1'b0, 1'b1});
      vecs.push_back('{750,  1250, 1'b1, 750,  2047, 1'b0, 1'b0});
      vecs.push_back('{750,  1250, 1'b1, 750,  2047, 1'b0, 1'b0});
      vecs.push_back('{500,  1500, 1'b1, 500,  0,    1'b0, 1'b0});
      vecs.push_back('{1000, 1000, 1'b1, 1000, 4095, 1'b0, 1'b0});
      vecs.push_back('{400,  1600, 1'b1, 400,  0,    1'b1, 1'b0});
      vecs.push_back('{1200, 800,  1'b1, 1200, 4095, 1'b1, 1'b0});
      vecs.push_back('{600,  1400, 1'b1, 600,  819,  1'b0, 1'b0});
      vecs.push_back('{5,    1995, 1'b0, 600,  819,  1'b0, 1'b0});
      vecs.push_back('{9,    1991, 1'b0, 600,  819,  1'b0, 1'b0});
      vecs.push_back('{10,   1990, 1'b1, 10,   0,    1'b1, 1'b0});
      vecs.push_back('{600,  1400, 1'b1, 600,  819,  1'b0, 1'b0});
      vecs.push_back('{1001, 999,  1'b1, 1001, 4095, 1'b1, 1'b0});
      vecs.push_back('{499,  1501, 1'b1, 499,  0,    1'b1, 1'b0});

      foreach (vecs[k]) begin
         model_apply(vecs[k].high, dummy);
         run_pulse($sformatf("vec%0d", k), vecs[k]);
      end

      for (int k = 0; k < 12; k++) begin
         hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14))
                                          : int'($urandom_range(400, 1100));
         lo = int'($urandom_range(20, 2900 - hi));
         model_pulse($sformatf("rand%0d", k), hi, lo);
      end

      // Valid pulse, then the line stays low until the loss timeout.
      @(negedge clk);
      pwm_in = 1'b1;
      n = 0;
      first_lost = 0;
      for (int i = 1; i <= TIMEOUT + 6; i++) begin
         @(posedge clk);
         #1;
         if (i == 600) pwm_in = 1'b0;
         if (meas_valid) n++;
         if (signal_lost && first_lost == 0) first_lost = i;
      end
      check("low_timeout_strobes", n, 1);
      check("low_timeout_cycle", first_lost, TIMEOUT + 3);
      check("low_timeout_width", int'(width_out), 600);
      check("low_timeout_pos", int'(position_out), 819);
      m_w = 600; m_p = 819; m_oor = 1'b0; m_lost = 1'b1; m_armed = 1'b0;

      model_pulse("rearm", 600, 1400);
      model_pulse("rearm2", 750, 1250);

      // Stuck-high input: loss at the timeout, and no strobe on the late fall.
      @(negedge clk);
      pwm_in = 1'b1;
      n = 0;
      first_lost = 0;
      for (int i = 1; i <= 4000; i++) begin
         @(posedge clk);
         #1;
         if (meas_valid) n++;
         if (signal_lost && first_lost == 0) first_lost = i;
      end
      pwm_in = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (meas_valid) n++;
      end
      check("stuck_cycle", first_lost, TIMEOUT + 3);
      check("stuck_strobes", n, 0);
      check("stuck_lost", int'(signal_lost), 1);
      check("stuck_width", int'(width_out), 750);
      m_lost = 1'b1;
      m_armed = 1'b1;
      model_pulse("recover", 800, 1250);

      // Reset in the middle of a pulse.
      model_pulse("pre_rst", 600, 1400);
      @(negedge clk);
      pwm_in = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_width", int'(width_out), 750);
      check("midrst_pos", int'(position_out), 2047);
      check("midrst_valid", int'(meas_valid), 0);
      check("midrst_oor", int'(out_of_range), 0);
      check("midrst_lost", int'(signal_lost), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (448) @(negedge clk);
      pwm_in = 1'b0;
      n = 0;
      for (int i = 1; i <= 500; i++) begin
         @(posedge clk);
         #1;
         if (meas_valid) n++;
      end
      check("midrst_tail_strobes", n, 0);
      model_reset();
      m_armed = 1'b1;
      model_pulse("post_rst", 750, 1250);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/servo_pwm_capture.md
Name: servo_pwm_capture

Overview:
Measures the high time of an incoming servo PWM pulse (1–2 ms in a 20 ms frame, 50 MHz clock) and reports it both as a duty-count and as a 12-bit position on the same scale the PID controller uses for its desired-position and feedback inputs. It is the receive end of the duty-count → pulse interface. Its output drives the PID feedback input or decodes an external R/C command into a position setpoint. It also flags glitches, out-of-range pulses and signal loss.

Parameters:
MIN_DUTY, 50000, pulse width in clk cycles that maps to position 0 (0 deg)
MAX_DUTY, 100000, pulse width in clk cycles that maps to position 4095 (180 deg)
GLITCH_CYC, 1000, high pulses shorter than this are discarded
TIMEOUT_CYC, 1200000, maximum cycles from one rising edge to the next before the signal is declared lost
SCALE_MUL, 5368, position multiplier: pos = ((w-MIN_DUTY)*SCALE_MUL) >> SCALE_SHIFT
SCALE_SHIFT, 16, position right-shift

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
pwm_in  in  1  asynchronous servo PWM input
width_out  out  18  last accepted high time in clk cycles, saturating
position_out  out  12  last accepted position, clamped to 0..4095
meas_valid  out  1  one-cycle strobe: width_out, position_out and out_of_range have just updated
out_of_range  out  1  last accepted width was <MIN_DUTY or >MAX_DUTY
signal_lost  out  1  no rising edge within TIMEOUT_CYC, or stuck high

Behaviour:
- Reset is asynchronous, active-high.
  - Reset values: width_out=75000, position_out=2047, meas_valid=0, out_of_range=0, signal_lost=1, FSM=IDLE, all counters 0.
- Input path: 2-FF synchronizer, then an edge-detect register. This produces single-cycle rise/fall strobes on the synchronized signal s.
- Width semantics: width = number of clk cycles s is high. An ideal N-cycle pulse yields exactly N.
- Width counter: 18 bits, saturates at 262143.
- Period counter: 21 bits, cleared on each rise strobe, saturates.
- FSM states:
  - IDLE: wait for a fall strobe. This discards any partial pulse after reset or loss. On fall → WAIT_RISE.
  - WAIT_RISE: on rise → HIGH, with width counter = 1 and period counter = 0.
  - HIGH: width counter increments each cycle.
    - On fall: if width < GLITCH_CYC, discard (no strobe, outputs hold) and → WAIT_RISE. Otherwise, capture the width into the conversion stage and → WAIT_RISE.
- Conversion stage (1 register):
  - w<MIN_DUTY → pos=0, oor=1.
  - w>MAX_DUTY → pos=4095, oor=1.
  - Otherwise pos = ((w-MIN_DUTY)*SCALE_MUL)>>SCALE_SHIFT, then min(pos,4095), oor=0.
  - Product fits in 32 bits, unsigned.
- Latency: meas_valid asserts on the 4th clk edge after the first edge that samples pwm_in low (2 sync + 1 edge + 1 conversion).
- On that same cycle, width_out, position_out and out_of_range update, and signal_lost clears.
- Out-of-range pulses are still accepted and strobed. Only glitches are discarded.
- Timeout: the period counter runs in WAIT_RISE and HIGH.
  - When it reaches TIMEOUT_CYC: signal_lost=1, FSM → IDLE, and position_out/width_out hold their last accepted values.
  - A stuck-high input therefore times out and then requires a falling edge before measuring again.
- Simultaneous events: a rise strobe on the same cycle the timeout is reached wins. No loss is flagged and the new pulse starts.
- signal_lost is cleared only by an accepted (non-glitch) measurement.
- Reset mid-pulse: outputs return to reset values immediately. After release, the FSM is in IDLE, so the in-progress pulse is ignored.

Decomposition:
- Package servo_pkg:
  - typedef duty_t = logic [17:0], typedef pos_t = logic [11:0].
  - Constants MIN_DUTY=50000, CENTER_DUTY=75000, MAX_DUTY=100000, POS_MAX=4095.
  - FSM state enum (IDLE, WAIT_RISE, HIGH).
  - The PID controller will use the same constants.
- Sub-module sync_edge_detect: 2-FF synchronizer plus edge register. Outputs: level s, rise strobe, fall strobe.

Test Plan:
- 75000-cycle high / 925000 low, 3 frames → each frame: meas_valid 1 cycle, 4 cycles after fall; width_out=75000, position_out=2047, out_of_range=0; signal_lost 1→0 on first strobe.
- Pulses of 50000 then 100000 → position_out 0 then 4095, out_of_range=0 both.
- Pulses of 40000 then 120000 → width_out 40000/120000, position_out 0/4095, out_of_range=1, meas_valid still asserted.
- After a valid 60000 pulse, a 100-cycle glitch → no meas_valid, outputs hold at 60000/819; next 60000 pulse strobes normally.
- pwm_in held low after a valid pulse → signal_lost=1 exactly TIMEOUT_CYC cycles after the last rise strobe. pwm_in held high 2M cycles → signal_lost=1 at TIMEOUT_CYC, no strobe at the eventual fall; next full pulse clears it.
- rst pulsed at cycle 30000 of a 75000 pulse → outputs immediately 75000/2047/0/0/1; the remainder of that pulse produces no strobe; the following frame measures 75000.
